// File: rtl/period_sequencer.sv
// period_sequencer
//   Multi-period match clock for the scoreboard. A start pulse runs an optional
//   prelim countdown, then NUM_PERIODS game periods with optional breaks in
//   between, all advanced by a 1 Hz tick enable. The remaining time is shown as
//   MM:SS on four active-low 7-segment digits. Pause blinks the display; abort
//   returns to IDLE from anywhere.
//
// Ports
//   Clk100M    in   system clock, all state on posedge
//   Rst_n      in   asynchronous active-low reset
//   Tick1Hz    in   one-cycle enable, once per second
//   startSig   in   begin match (IDLE only)
//   pauseSig   in   toggle pause (PRELIM/GAME/BREAK only)
//   abortSig   in   return to IDLE from any phase
//   gameSig    out  high while phase is GAME
//   periodNum  out  current game period, 0 in IDLE/PRELIM
//   phase      out  0 IDLE, 1 PRELIM, 2 GAME, 3 BREAK, 4 FINISHED
//   matchDone  out  high in FINISHED
//   seg3..seg0 out  M-tens, M-units, S-tens, S-units; bit7 = DP, 0 = lit
module period_sequencer #(
  parameter int NUM_PERIODS = 4,
  parameter int PRELIM_SECS = 30,
  parameter int PERIOD_SECS = 600,
  parameter int BREAK_SECS  = 120
) (
  input  logic       Clk100M,
  input  logic       Rst_n,
  input  logic       Tick1Hz,
  input  logic       startSig,
  input  logic       pauseSig,
  input  logic       abortSig,
  output logic       gameSig,
  output logic [3:0] periodNum,
  output logic [2:0] phase,
  output logic       matchDone,
  output logic [7:0] seg3,
  output logic [7:0] seg2,
  output logic [7:0] seg1,
  output logic [7:0] seg0
);

  localparam int MAX_PB   = (PRELIM_SECS > PERIOD_SECS) ? PRELIM_SECS : PERIOD_SECS;
  localparam int MAX_SECS = (MAX_PB > BREAK_SECS) ? MAX_PB : BREAK_SECS;
  localparam int TW       = $clog2(MAX_SECS + 1);

  localparam logic [TW-1:0] PRELIM_LD   = TW'(PRELIM_SECS);
  localparam logic [TW-1:0] PERIOD_LD   = TW'(PERIOD_SECS);
  localparam logic [TW-1:0] BREAK_LD    = TW'(BREAK_SECS);
  localparam logic [3:0]    LAST_PERIOD = 4'(NUM_PERIODS);

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_PRELIM   = 3'd1,
    PH_GAME     = 3'd2,
    PH_BREAK    = 3'd3,
    PH_FINISHED = 3'd4
  } phase_e;

  phase_e          phase_q,  phase_d;
  logic [TW-1:0]   remain_q, remain_d;
  logic [3:0]      per_q,    per_d;
  logic            paused_q, paused_d;
  logic            blink_q,  blink_d;

  // Active-low segment pattern for one decimal digit, DP off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    phase_d  = phase_q;
    remain_d = remain_q;
    per_d    = per_q;
    paused_d = paused_q;
    blink_d  = blink_q;

    if (abortSig) begin
      phase_d  = PH_IDLE;
      remain_d = '0;
      per_d    = '0;
      paused_d = 1'b0;
      blink_d  = 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (startSig) begin
            if (PRELIM_SECS == 0) begin
              phase_d  = PH_GAME;
              per_d    = 4'd1;
              remain_d = PERIOD_LD;
            end else begin
              phase_d  = PH_PRELIM;
              remain_d = PRELIM_LD;
            end
          end
        end

        PH_PRELIM, PH_GAME, PH_BREAK: begin
          if (Tick1Hz) begin
            // The tick is judged against the pause state before this cycle's
            // pause pulse: counted on pause-on, swallowed on pause-off.
            if (paused_q) begin
              blink_d = ~blink_q;
            end else if (remain_q > TW'(1)) begin
              remain_d = remain_q - TW'(1);
            end else begin
              case (phase_q)
                PH_PRELIM: begin
                  phase_d  = PH_GAME;
                  per_d    = 4'd1;
                  remain_d = PERIOD_LD;
                end
                PH_BREAK: begin
                  phase_d  = PH_GAME;
                  per_d    = per_q + 4'd1;
                  remain_d = PERIOD_LD;
                end
                default: begin
                  if (per_q >= LAST_PERIOD) begin
                    phase_d  = PH_FINISHED;
                    remain_d = '0;
                  end else if (BREAK_SECS == 0) begin
                    per_d    = per_q + 4'd1;
                    remain_d = PERIOD_LD;
                  end else begin
                    phase_d  = PH_BREAK;
                    remain_d = BREAK_LD;
                  end
                end
              endcase
            end
          end
          // Each pause toggle restarts blinking from the visible half.
          if (pauseSig) begin
            paused_d = ~paused_q;
            blink_d  = 1'b0;
          end
          if (phase_d == PH_FINISHED) begin
            paused_d = 1'b0;
            blink_d  = 1'b0;
          end
        end

        default: ;  // FINISHED holds until abort
      endcase
    end
  end

  // Display digits derived from the current state; registered below.
  logic [31:0] min_w, sec_w;
  assign min_w = 32'(remain_q) / 32'd60;
  assign sec_w = 32'(remain_q) % 32'd60;

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      phase_q   <= PH_IDLE;
      remain_q  <= '0;
      per_q     <= '0;
      paused_q  <= 1'b0;
      blink_q   <= 1'b0;
      gameSig   <= 1'b0;
      periodNum <= '0;
      phase     <= PH_IDLE;
      matchDone <= 1'b0;
      seg3      <= 8'hFF;
      seg2      <= 8'hFF;
      seg1      <= 8'hFF;
      seg0      <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before this edge regardless of statement order.
      phase_q  <= phase_d;
      remain_q <= remain_d;
      per_q    <= per_d;
      paused_q <= paused_d;
      blink_q  <= blink_d;

      // Outputs follow the state registers one clock later.
      gameSig   <= (phase_q == PH_GAME);
      periodNum <= per_q;
      phase     <= phase_q;
      matchDone <= (phase_q == PH_FINISHED);
      if (phase_q == PH_IDLE || (paused_q && blink_q)) begin
        seg3 <= 8'hFF;
        seg2 <= 8'hFF;
        seg1 <= 8'hFF;
        seg0 <= 8'hFF;
      end else begin
        seg3 <= seg7(4'(min_w / 32'd10));
        seg2 <= seg7(4'(min_w % 32'd10)) & 8'h7F;  // colon DP lit
        seg1 <= seg7(4'(sec_w / 32'd10));
        seg0 <= seg7(4'(sec_w % 32'd10));
      end
    end
  end

endmodule

// File: tb/tb_period_sequencer.sv
// tb_period_sequencer
//   Three instances share one stimulus stream:
//     0 (A): PRELIM=3, PERIOD=5, BREAK=2, N=2
//     1 (D): default parameters
//     2 (Z): PRELIM=0, PERIOD=3, BREAK=0, N=2
//   Each step drives one input cycle, pushes the expected outputs for one
//   instance onto a scoreboard queue, and pops/compares once the registered
//   outputs have settled.
module tb_period_sequencer;

  logic clk = 1'b0;
  logic rst_n, tick, start, pause, abort;

  logic       game_w [3];
  logic [3:0] per_w  [3];
  logic [2:0] ph_w   [3];
  logic       done_w [3];
  logic [7:0] s3_w [3], s2_w [3], s1_w [3], s0_w [3];

  always #5 clk = ~clk;

  period_sequencer #(.NUM_PERIODS(2), .PRELIM_SECS(3), .PERIOD_SECS(5), .BREAK_SECS(2)) u_a (
    .Clk100M(clk), .Rst_n(rst_n), .Tick1Hz(tick), .startSig(start), .pauseSig(pause),
    .abortSig(abort), .gameSig(game_w[0]), .periodNum(per_w[0]), .phase(ph_w[0]),
    .matchDone(done_w[0]), .seg3(s3_w[0]), .seg2(s2_w[0]), .seg1(s1_w[0]), .seg0(s0_w[0]));

  period_sequencer u_d (
    .Clk100M(clk), .Rst_n(rst_n), .Tick1Hz(tick), .startSig(start), .pauseSig(pause),
    .abortSig(abort), .gameSig(game_w[1]), .periodNum(per_w[1]), .phase(ph_w[1]),
    .matchDone(done_w[1]), .seg3(s3_w[1]), .seg2(s2_w[1]), .seg1(s1_w[1]), .seg0(s0_w[1]));

  period_sequencer #(.NUM_PERIODS(2), .PRELIM_SECS(0), .PERIOD_SECS(3), .BREAK_SECS(0)) u_z (
    .Clk100M(clk), .Rst_n(rst_n), .Tick1Hz(tick), .startSig(start), .pauseSig(pause),
    .abortSig(abort), .gameSig(game_w[2]), .periodNum(per_w[2]), .phase(ph_w[2]),
    .matchDone(done_w[2]), .seg3(s3_w[2]), .seg2(s2_w[2]), .seg1(s1_w[2]), .seg0(s0_w[2]));

  typedef struct {
    bit t, s, p, a;
    int ph, per, rem;
    bit blank;
  } vec_t;

  typedef struct {
    string name;
    int    dut;
    int    ph, per, rem;
    bit    blank;
  } exp_t;

  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  function automatic exp_t mk(input string n, input int d, input int ph, input int per,
                              input int rem, input bit blank);
    exp_t e;
    e.name = n; e.dut = d; e.ph = ph; e.per = per; e.rem = rem; e.blank = blank;
    return e;
  endfunction

  function automatic vec_t v(input bit t, input bit s, input bit p, input bit a,
                             input int ph, input int per, input int rem, input bit blank);
    vec_t x;
    x.t = t; x.s = s; x.p = p; x.a = a; x.ph = ph; x.per = per; x.rem = rem; x.blank = blank;
    return x;
  endfunction

  // Expected output bundle {gameSig, periodNum, phase, matchDone, seg3..seg0}
  function automatic logic [40:0] model(input exp_t e);
    logic [7:0] s3, s2, s1, s0;
    int mn, sc;
    s3 = 8'hFF; s2 = 8'hFF; s1 = 8'hFF; s0 = 8'hFF;
    if (e.ph != 0 && !e.blank) begin
      mn = e.rem / 60;
      sc = e.rem % 60;
      s3 = SEG[mn / 10];
      s2 = SEG[mn % 10] & 8'h7F;
      s1 = SEG[sc / 10];
      s0 = SEG[sc % 10];
    end
    return {(e.ph == 2), 4'(e.per), 3'(e.ph), (e.ph == 4), s3, s2, s1, s0};
  endfunction

  function automatic logic [40:0] act(input int d);
    return {game_w[d], per_w[d], ph_w[d], done_w[d], s3_w[d], s2_w[d], s1_w[d], s0_w[d]};
  endfunction

  task automatic check(input string name, input logic [40:0] got, input logic [40:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One input cycle, then wait for the registered outputs and compare.
  task automatic step(input bit t, input bit s, input bit p, input bit a, input exp_t e);
    exp_t x;
    @(negedge clk);
    tick = t; start = s; pause = p; abort = a;
    sb.push_back(e);
    @(negedge clk);
    tick = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      x = sb.pop_front();
      check(x.name, act(x.dut), model(x));
    end
  endtask

  initial begin
    vec_t tv[$];

    // Idle behaviour, then the full short match on instance A.
    for (int i = 0; i < 5; i++) tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 1'b0));
    tv.push_back(v(0, 0, 1, 0, 0, 0, 0, 1'b0));  // pause ignored in IDLE
    tv.push_back(v(0, 1, 0, 0, 1, 0, 3, 1'b0));  // start -> PRELIM 00:03
    tv.push_back(v(1, 0, 0, 0, 1, 0, 2, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 1, 0, 1, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 2, 1, 5, 1'b0));  // GAME period 1
    tv.push_back(v(1, 0, 0, 0, 2, 1, 4, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 2, 1, 3, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 2, 1, 2, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 2, 1, 1, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 3, 1, 2, 1'b0));  // BREAK
    tv.push_back(v(1, 0, 0, 0, 3, 1, 1, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 2, 2, 5, 1'b0));  // GAME period 2
    tv.push_back(v(1, 0, 0, 0, 2, 2, 4, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 2, 2, 3, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 2, 2, 2, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 2, 2, 1, 1'b0));
    tv.push_back(v(1, 0, 0, 0, 4, 2, 0, 1'b0));  // FINISHED 00:00
    tv.push_back(v(1, 0, 0, 0, 4, 2, 0, 1'b0));
    tv.push_back(v(0, 1, 0, 0, 4, 2, 0, 1'b0));  // start ignored in FINISHED
    tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 1'b0));  // abort -> IDLE

    rst_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("reset_dut%0d", d), act(d), model(mk("", d, 0, 0, 0, 1'b0)));
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++)
      step(tv[i].t, tv[i].s, tv[i].p, tv[i].a,
           mk($sformatf("tbl%0d", i), 0, tv[i].ph, tv[i].per, tv[i].rem, tv[i].blank));

    // Default parameters: start + 31 ticks lands on GAME period 1 at 09:59.
    step(0, 0, 0, 1, mk("d_abort", 1, 0, 0, 0, 1'b0));
    step(0, 1, 0, 0, mk("d_start", 1, 1, 0, 30, 1'b0));
    for (int k = 1; k <= 31; k++) begin
      if (k < 30) step(1, 0, 0, 0, mk($sformatf("d_tick%0d", k), 1, 1, 0, 30 - k, 1'b0));
      else        step(1, 0, 0, 0, mk($sformatf("d_tick%0d", k), 1, 2, 1, 630 - k, 1'b0));
    end
    check("d_0959_segs", {9'd0, s3_w[1], s2_w[1], s1_w[1], s0_w[1]},
          {9'd0, 8'hC0, 8'h10, 8'h92, 8'h90});

    // Pause: pulse coincident with a tick at remain=7, then blink while held.
    step(0, 0, 0, 1, mk("p_abort", 1, 0, 0, 0, 1'b0));
    step(0, 1, 0, 0, mk("p_start", 1, 1, 0, 30, 1'b0));
    for (int k = 1; k <= 23; k++)
      step(1, 0, 0, 0, mk($sformatf("p_run%0d", k), 1, 1, 0, 30 - k, 1'b0));
    step(1, 0, 1, 0, mk("p_on_tick", 1, 1, 0, 6, 1'b0));
    for (int k = 0; k < 4; k++)
      step(1, 0, 0, 0, mk($sformatf("p_blink%0d", k), 1, 1, 0, 6, (k % 2) == 0));
    step(0, 0, 1, 0, mk("p_off", 1, 1, 0, 6, 1'b0));
    step(1, 0, 0, 0, mk("p_resume", 1, 1, 0, 5, 1'b0));
    step(0, 0, 1, 0, mk("p_on2", 1, 1, 0, 5, 1'b0));
    step(1, 0, 1, 0, mk("p_off_tick", 1, 1, 0, 5, 1'b0));  // tick swallowed
    step(1, 0, 0, 0, mk("p_after", 1, 1, 0, 4, 1'b0));

    // Abort mid-GAME together with tick and start, then restart.
    step(0, 0, 0, 1, mk("a_abort0", 0, 0, 0, 0, 1'b0));
    step(0, 1, 0, 0, mk("a_start", 0, 1, 0, 3, 1'b0));
    step(1, 0, 0, 0, mk("a_t1", 0, 1, 0, 2, 1'b0));
    step(1, 0, 0, 0, mk("a_t2", 0, 1, 0, 1, 1'b0));
    step(1, 0, 0, 0, mk("a_t3", 0, 2, 1, 5, 1'b0));
    step(1, 0, 0, 0, mk("a_t4", 0, 2, 1, 4, 1'b0));
    step(1, 1, 0, 1, mk("a_abort_all", 0, 0, 0, 0, 1'b0));
    step(0, 1, 0, 0, mk("a_restart", 0, 1, 0, 3, 1'b0));
    step(1, 0, 0, 0, mk("a_restart_t", 0, 1, 0, 2, 1'b0));

    // No prelim, no breaks.
    step(0, 0, 0, 1, mk("z_abort", 2, 0, 0, 0, 1'b0));
    step(0, 1, 0, 0, mk("z_start", 2, 2, 1, 3, 1'b0));
    step(1, 0, 0, 0, mk("z_t1", 2, 2, 1, 2, 1'b0));
    step(1, 0, 0, 0, mk("z_t2", 2, 2, 1, 1, 1'b0));
    step(1, 0, 0, 0, mk("z_t3", 2, 2, 2, 3, 1'b0));
    step(1, 0, 0, 0, mk("z_t4", 2, 2, 2, 2, 1'b0));
    step(1, 0, 0, 0, mk("z_t5", 2, 2, 2, 1, 1'b0));
    step(1, 0, 0, 0, mk("z_t6", 2, 4, 2, 0, 1'b0));

    // Reset asserted mid-count clears outputs immediately.
    step(0, 0, 0, 1, mk("r_abort", 0, 0, 0, 0, 1'b0));
    step(0, 1, 0, 0, mk("r_start", 0, 1, 0, 3, 1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("r_async_a", act(0), model(mk("", 0, 0, 0, 0, 1'b0)));
    check("r_async_d", act(1), model(mk("", 1, 0, 0, 0, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, mk("r_after", 0, 0, 0, 0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
